axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
// - AXI3 slave (responder) that terminates the read/write channels driven by the crossbar master port of the
//   CPU cache wrapper: 4-bit ARID, ARLEN bursts on AR/R, single-beat writes on AW/W/B.
// - Backed by a byte-enabled word RAM; used as the simulation/FPGA memory behind the CPU and as a bench target
//   for the I/D cache refill paths.
// - Independent read and write engines; programmable read latency.
// PARAMETERS
// - ADDR_BITS   14  word-address width (RAM depth 2**ADDR_BITS words; 14 -> 64 KB)
// - RD_LATENCY  2   cycles from AR handshake to first RVALID, counted in R_WAIT; 0 = next cycle
// - WR_LATENCY  1   cycles spent in W_COMMIT before BVALID (>=1)
// PORTS
// - clk            in   1   single clock, all logic posedge
// - reset          in   1   synchronous, active-high
// - s_axi_arid     in   4   read ID, returned on RID
// - s_axi_araddr   in   32  byte address, bits [1:0] ignored
// - s_axi_arlen    in   4   beats-1 (INCR only)
// - s_axi_arsize   in   3   accepted, treated as 3'd2
// - s_axi_arvalid  in   1
// - s_axi_arready  out  1
// - s_axi_rid      out  4
// - s_axi_rdata    out  32
// - s_axi_rlast    out  1
// - s_axi_rvalid   out  1
// - s_axi_rready   in   1
// - s_axi_awaddr   in   32  byte address, bits [1:0] ignored
// - s_axi_awsize   in   3   accepted, treated as 3'd2
// - s_axi_awvalid  in   1
// - s_axi_awready  out  1
// - s_axi_wdata    in   32
// - s_axi_wstrb    in   4   per-byte write enable
// - s_axi_wvalid   in   1   single beat; WLAST not needed
// - s_axi_wready   out  1
// - s_axi_bvalid   out  1   response always OKAY (no BRESP port)
// - s_axi_bready   in   1
// BEHAVIOUR
// - Clock clk; reset synchronous active-high. Reset: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, awready=0,
//   wready=0, bvalid=0; both FSMs idle; RAM contents NOT cleared. Reset mid-burst abandons it, no further beats.
// - Word index = addr[ADDR_BITS+1:2]; upper bits ignored (aliasing). Burst index wraps mod 2**ADDR_BITS.
// - Read FSM R_IDLE/R_WAIT/R_BURST. arready=1 only in R_IDLE. AR handshake latches id, index, len, beat=0;
//   -> R_WAIT (cnt=RD_LATENCY) or R_BURST if RD_LATENCY==0. R_WAIT decrements; at 0 loads rdata=mem[index],
//   -> R_BURST. R_BURST: rvalid=1, rlast=(beat==len). On rvalid&rready: not last -> index+1, beat+1, rdata
//   reloaded same edge (back-to-back beats, no bubble); last -> rvalid=0, R_IDLE (next AR accepted one cycle later).
// - rid/rdata/rlast stable while rvalid&~rready (AXI hold rule).
// - Write FSM W_COLLECT/W_COMMIT/W_RESP. In W_COLLECT awready=~aw_got, wready=~w_got; AW and W in either
//   order or same cycle; each latched once. Both held -> W_COMMIT (WR_LATENCY cycles); last cycle writes
//   mem[idx] bytes where wstrb=1 -> W_RESP: bvalid=1 until bready, then W_COLLECT with aw_got=w_got=0.
// - wstrb=4'b0000 completes normally (B returned), RAM untouched.
// - Read/write collision: rdata load on same edge as commit to same word returns pre-write data; any load a
//   later cycle returns new data. Read FSM never waits on write FSM.
// STRUCTURE
// - Package axi_resp_pkg: rd_state_t {R_IDLE,R_WAIT,R_BURST}, wr_state_t {W_COLLECT,W_COMMIT,W_RESP},
//   AXI_SIZE_WORD=3'd2, AXI_ID_W=4.
// - Sub-module axi_resp_ram: 2**ADDR_BITS x 32, one async-read port, one byte-enabled sync write port.
// - Top holds both FSMs, RD_LATENCY counter, beat counter, AW/W capture registers.
// TESTING
// - Preload mem[0x100>>2..+3]=A0..A3; AR addr=0x100 len=3 id=1, rready=1 -> RVALID RD_LATENCY+1 cycles after
//   AR; beats A0..A3 consecutive, rid=1, rlast only on beat 4.
// - Same burst, rready toggled 1,0,0,1,... -> rdata/rlast held during stalls; no beat lost or duplicated.
// - W (0xDEADBEEF, wstrb=4'b0011) 3 cycles before AW addr=0x200 -> one bvalid; read 0x200 over old 0x11223344
//   returns 0x1122BEEF.
// - AW and W same cycle with bready=0 for 5 cycles -> bvalid held, awready=wready=0 until B handshake.
// - AR to 0x300 issued same cycle W commits 0x300, RD_LATENCY=0 -> first beat old data; repeat read -> new data.
// - Assert reset mid-burst (beat 2 of 4) -> next cycle rvalid=0, arready=0; after release arready=1, memory
//   retained.

Source files
------------

// File: rtl/axi_sram_responder_pkg.sv
// Shared types and constants for the AXI3 SRAM responder.
//   rd_state_t    : read engine states
//   wr_state_t    : write engine states
//   AXI_SIZE_WORD : the only transfer size the responder honours (4 bytes)
//   AXI_ID_W      : width of ARID/RID
package axi_resp_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_COMMIT  = 2'd1,
        W_RESP    = 2'd2
    } wr_state_t;

    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
    localparam int         AXI_ID_W      = 4;

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI3 read (AR/R) and single-beat write (AW/W/B) channel bundle.
//   master modport : crossbar / bench side, drives requests and RREADY/BREADY
//   slave modport  : responder side, drives READY strobes, R data and BVALID
interface axi_sram_responder_if;
    import axi_resp_pkg::*;

    logic [AXI_ID_W-1:0] s_axi_arid;
    logic [31:0]         s_axi_araddr;
    logic [3:0]          s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [AXI_ID_W-1:0] s_axi_rid;
    logic [31:0]         s_axi_rdata;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [31:0]         s_axi_awaddr;
    logic [2:0]          s_axi_awsize;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [31:0]         s_axi_wdata;
    logic [3:0]          s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        input  s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bvalid,
        input  s_axi_bready
    );

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        output s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bvalid,
        output s_axi_bready
    );

endinterface

// File: rtl/axi_sram_responder_ram.sv
// Word RAM behind the responder: 2**ADDR_BITS x 32, one asynchronous read
// port and one byte-enabled synchronous write port. Contents are not reset.
//   clk     : write clock
//   i_we    : write enable, i_waddr/i_wdata/i_wstrb : write word, data, byte lanes
//   i_raddr : read address, o_rdata : combinational read data
module axi_resp_ram #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_wstrb,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [2**ADDR_BITS];

    // A read on the same edge as a write sees the old word.
    assign o_rdata = r_mem[i_raddr];

    // Byte-lane write; lanes with a clear strobe keep their old contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 SRAM responder: INCR read bursts on AR/R with programmable latency,
// single-beat byte-enabled writes on AW/W/B (BRESP implicitly OKAY).
//   clk, reset : single clock, synchronous active-high reset
//   s_axi      : AXI channel bundle (slave modport)
// Read and write engines are independent; the read engine never waits on writes.
module axi_sram_responder
    import axi_resp_pkg::*;
#(
    parameter int ADDR_BITS  = 14,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_sram_responder_if.slave   s_axi
);

    // R_WAIT holds RD_LATENCY cycles: the counter starts one below and loads data at 0.
    localparam int RD_INIT = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
    localparam int WR_INIT = (WR_LATENCY > 1) ? WR_LATENCY - 1 : 0;
    localparam logic [ADDR_BITS-1:0] IDX_ONE = ADDR_BITS'(1);

    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [7:0]            r_rd_cnt, w_rd_cnt_nxt;
    logic [ADDR_BITS-1:0]  r_rd_idx, w_rd_idx_nxt, w_ram_raddr, w_ar_idx;
    logic [3:0]            r_rd_beat, w_rd_beat_nxt, r_rd_len, w_rd_len_nxt;
    logic [AXI_ID_W-1:0]   r_rid, w_rid_nxt;
    logic [31:0]           r_rdata, w_rdata_nxt, w_ram_rdata;
    logic                  r_rvalid, w_rvalid_nxt, r_rlast, w_rlast_nxt;
    logic                  r_arready, w_arready_nxt;

    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic [7:0]            r_wr_cnt, w_wr_cnt_nxt;
    logic                  r_aw_got, w_aw_got_nxt, r_w_got, w_w_got_nxt;
    logic [ADDR_BITS-1:0]  r_aw_idx, w_aw_idx_nxt;
    logic [31:0]           r_wdata, w_wdata_nxt;
    logic [3:0]            r_wstrb, w_wstrb_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic                  r_awready, w_awready_nxt, r_wready, w_wready_nxt;
    logic                  w_ram_we;
    logic                  w_unused_bits;

    assign w_ar_idx = s_axi.s_axi_araddr[ADDR_BITS+1:2];

    // Address aliasing and the size fields carry no information here.
    assign w_unused_bits = ^{s_axi.s_axi_araddr[31:ADDR_BITS+2], s_axi.s_axi_araddr[1:0],
                             s_axi.s_axi_awaddr[31:ADDR_BITS+2], s_axi.s_axi_awaddr[1:0],
                             s_axi.s_axi_arsize ^ AXI_SIZE_WORD, s_axi.s_axi_awsize ^ AXI_SIZE_WORD};

    axi_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_aw_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // RAM read address: the word whose data is loaded into rdata on the coming edge.
    always_comb begin
        w_ram_raddr = w_ar_idx;
        case (r_rd_state)
            R_IDLE:  w_ram_raddr = w_ar_idx;
            R_WAIT:  w_ram_raddr = r_rd_idx;
            R_BURST: w_ram_raddr = r_rd_idx + IDX_ONE;
            default: w_ram_raddr = w_ar_idx;
        endcase
    end

    // Read engine next-state and next R-channel values.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_rd_idx_nxt   = r_rd_idx;
        w_rd_beat_nxt  = r_rd_beat;
        w_rd_len_nxt   = r_rd_len;
        w_rid_nxt      = r_rid;
        w_rdata_nxt    = r_rdata;
        w_rvalid_nxt   = r_rvalid;
        w_rlast_nxt    = r_rlast;
        case (r_rd_state)
            R_IDLE: begin
                if (s_axi.s_axi_arvalid && r_arready) begin
                    w_rid_nxt     = s_axi.s_axi_arid;
                    w_rd_idx_nxt  = w_ar_idx;
                    w_rd_len_nxt  = s_axi.s_axi_arlen;
                    w_rd_beat_nxt = 4'd0;
                    if (RD_LATENCY == 0) begin
                        w_rdata_nxt    = w_ram_rdata;
                        w_rvalid_nxt   = 1'b1;
                        w_rlast_nxt    = (s_axi.s_axi_arlen == 4'd0);
                        w_rd_state_nxt = R_BURST;
                    end else begin
                        w_rd_cnt_nxt   = 8'(RD_INIT);
                        w_rd_state_nxt = R_WAIT;
                    end
                end else begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_rd_cnt == 8'd0) begin
                    w_rdata_nxt    = w_ram_rdata;
                    w_rvalid_nxt   = 1'b1;
                    w_rlast_nxt    = (r_rd_len == 4'd0);
                    w_rd_state_nxt = R_BURST;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt - 8'd1;
                end
            end
            R_BURST: begin
                if (r_rvalid && s_axi.s_axi_rready) begin
                    if (r_rlast) begin
                        w_rvalid_nxt   = 1'b0;
                        w_rlast_nxt    = 1'b0;
                        w_rd_state_nxt = R_IDLE;
                    end else begin
                        // Next beat loads on the handshake edge, so beats run back to back.
                        w_rd_idx_nxt  = r_rd_idx + IDX_ONE;
                        w_rd_beat_nxt = r_rd_beat + 4'd1;
                        w_rdata_nxt   = w_ram_rdata;
                        w_rlast_nxt   = ((r_rd_beat + 4'd1) == r_rd_len);
                    end
                end else begin
                    w_rd_state_nxt = R_BURST;
                end
            end
            default: begin
                w_rvalid_nxt   = 1'b0;
                w_rd_state_nxt = R_IDLE;
            end
        endcase
        w_arready_nxt = (w_rd_state_nxt == R_IDLE);
    end

    // Write engine next-state: capture AW and W once each, commit, then respond.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_aw_got_nxt   = r_aw_got;
        w_w_got_nxt    = r_w_got;
        w_aw_idx_nxt   = r_aw_idx;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_bvalid_nxt   = r_bvalid;
        w_ram_we       = 1'b0;
        case (r_wr_state)
            W_COLLECT: begin
                if (s_axi.s_axi_awvalid && r_awready) begin
                    w_aw_got_nxt = 1'b1;
                    w_aw_idx_nxt = s_axi.s_axi_awaddr[ADDR_BITS+1:2];
                end else begin
                    w_aw_got_nxt = r_aw_got;
                end
                if (s_axi.s_axi_wvalid && r_wready) begin
                    w_w_got_nxt = 1'b1;
                    w_wdata_nxt = s_axi.s_axi_wdata;
                    w_wstrb_nxt = s_axi.s_axi_wstrb;
                end else begin
                    w_w_got_nxt = r_w_got;
                end
                if (w_aw_got_nxt && w_w_got_nxt) begin
                    w_wr_cnt_nxt   = 8'(WR_INIT);
                    w_wr_state_nxt = W_COMMIT;
                end else begin
                    w_wr_state_nxt = W_COLLECT;
                end
            end
            W_COMMIT: begin
                if (r_wr_cnt == 8'd0) begin
                    w_ram_we       = 1'b1;
                    w_bvalid_nxt   = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end else begin
                    w_wr_cnt_nxt = r_wr_cnt - 8'd1;
                end
            end
            W_RESP: begin
                if (s_axi.s_axi_bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_aw_got_nxt   = 1'b0;
                    w_w_got_nxt    = 1'b0;
                    w_wr_state_nxt = W_COLLECT;
                end else begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            default: begin
                w_bvalid_nxt   = 1'b0;
                w_aw_got_nxt   = 1'b0;
                w_w_got_nxt    = 1'b0;
                w_wr_state_nxt = W_COLLECT;
            end
        endcase
        w_awready_nxt = (w_wr_state_nxt == W_COLLECT) && !w_aw_got_nxt;
        w_wready_nxt  = (w_wr_state_nxt == W_COLLECT) && !w_w_got_nxt;
    end

    // State and output registers for both engines.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= 8'd0;
            r_rd_idx   <= '0;
            r_rd_beat  <= 4'd0;
            r_rd_len   <= 4'd0;
            r_rid      <= '0;
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_arready  <= 1'b0;
            r_wr_state <= W_COLLECT;
            r_wr_cnt   <= 8'd0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_rd_beat  <= w_rd_beat_nxt;
            r_rd_len   <= w_rd_len_nxt;
            r_rid      <= w_rid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rlast    <= w_rlast_nxt;
            r_arready  <= w_arready_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_aw_got   <= w_aw_got_nxt;
            r_w_got    <= w_w_got_nxt;
            r_aw_idx   <= w_aw_idx_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
        end
    end

    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rid     = r_rid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rlast   = r_rlast;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: stimulus pushes expected R beats
// and B responses into queues; a negedge monitor compares them against the bus.
module tb_axi_sram_responder;

    localparam int RDL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_sram_responder_if bus ();

    axi_sram_responder #(.ADDR_BITS(14), .RD_LATENCY(RDL), .WR_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .s_axi (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    rbeat_t rq[$];
    bit     bq[$];
    int     total = 0;
    int     bad   = 0;
    int     lat;

    localparam logic [31:0] A0 = 32'hA000_1111;
    localparam logic [31:0] A1 = 32'hA100_2222;
    localparam logic [31:0] A2 = 32'hA200_3333;
    localparam logic [31:0] A3 = 32'hA300_4444;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        rbeat_t b;
        b.id = id; b.data = data; b.last = last;
        rq.push_back(b);
    endtask

    // R and B monitor: every presented beat is checked against the queue head, popped on handshake.
    always @(negedge clk) begin
        if (!reset && bus.s_axi_rvalid) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: got rdata %h expected no beat", bus.s_axi_rdata);
            end else begin
                check("rid", 32'(bus.s_axi_rid), 32'(rq[0].id));
                check("rdata", bus.s_axi_rdata, rq[0].data);
                check("rlast", 32'(bus.s_axi_rlast), 32'(rq[0].last));
                if (bus.s_axi_rready) void'(rq.pop_front());
            end
        end
        if (!reset && bus.s_axi_bvalid && bus.s_axi_bready) begin
            total++;
            if (bq.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: got bvalid 1 expected no response");
            end else begin
                void'(bq.pop_front());
            end
        end
    end

    task automatic wait_b();
        for (int i = 0; i < 30 && bq.size() != 0; i++) @(negedge clk);
        check("b_done", 32'(bq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        for (int i = 0; i < 80 && (rq.size() != 0 || bus.s_axi_rvalid); i++) @(negedge clk);
        check("r_done", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_hs, w_hs;
        bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata  = data; bus.s_axi_wstrb  = strb; bus.s_axi_wvalid = 1'b1;
        bq.push_back(1'b1);
        for (int i = 0; i < 20 && (bus.s_axi_awvalid || bus.s_axi_wvalid); i++) begin
            @(negedge clk);
            aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk); #1;
            if (aw_hs) bus.s_axi_awvalid = 1'b0;
            if (w_hs)  bus.s_axi_wvalid  = 1'b0;
        end
        check("write_accept", 32'(bus.s_axi_awvalid || bus.s_axi_wvalid), 32'd0);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        wait_b();
    endtask

    // Issues one AR and returns the negedge count from handshake to first RVALID.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         output int l);
        logic got;
        bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
        bus.s_axi_arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.s_axi_arready;
            @(posedge clk); #1;
        end
        bus.s_axi_arvalid = 1'b0;
        check("ar_accept", 32'(got), 32'd1);
        l = 0;
        for (int i = 0; i < 40 && !(l > 0 && bus.s_axi_rvalid); i++) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        int ar_t, w_t, t_max;
        reset = 1'b1;
        bus.s_axi_arid = 4'd0; bus.s_axi_araddr = 32'd0; bus.s_axi_arlen = 4'd0;
        bus.s_axi_arsize = 3'd2; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
        bus.s_axi_awaddr = 32'd0; bus.s_axi_awsize = 3'd2; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = 32'd0; bus.s_axi_wstrb = 4'd0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("rst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
        check("rst_rlast",   32'(bus.s_axi_rlast),   32'd0);
        check("rst_rid",     32'(bus.s_axi_rid),     32'd0);
        check("rst_rdata",   bus.s_axi_rdata,        32'd0);
        check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("rst_wready",  32'(bus.s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_arready", 32'(bus.s_axi_arready), 32'd1);
        check("post_rst_awready", 32'(bus.s_axi_awready), 32'd1);
        check("post_rst_wready",  32'(bus.s_axi_wready),  32'd1);

        // Preload through the write channel.
        write_word(32'h100, A0, 4'hF);
        write_word(32'h104, A1, 4'hF);
        write_word(32'h108, A2, 4'hF);
        write_word(32'h10C, A3, 4'hF);
        write_word(32'h200, 32'h1122_3344, 4'hF);
        write_word(32'h300, 32'h0BAD_F00D, 4'hF);

        // Four-beat burst with RREADY high: latency and back-to-back beats.
        push_r(4'd1, A0, 1'b0); push_r(4'd1, A1, 1'b0);
        push_r(4'd1, A2, 1'b0); push_r(4'd1, A3, 1'b1);
        do_ar(4'd1, 32'h100, 4'd3, lat);
        check("rd_latency", 32'(lat), 32'(RDL + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r_consecutive", 32'(bus.s_axi_rvalid), 32'd1);
        end
        @(negedge clk);
        check("r_end", 32'(bus.s_axi_rvalid), 32'd0);
        wait_r();

        // Same burst with RREADY stalls; monitor checks held beats each cycle.
        pat = 4'b1001;
        push_r(4'd2, A0, 1'b0); push_r(4'd2, A1, 1'b0);
        push_r(4'd2, A2, 1'b0); push_r(4'd2, A3, 1'b1);
        do_ar(4'd2, 32'h100, 4'd3, lat);
        for (int k = 1; k < 40 && rq.size() != 0; k++) begin
            @(posedge clk); #1;
            bus.s_axi_rready = pat[k % 4];
        end
        bus.s_axi_rready = 1'b1;
        wait_r();

        // W three cycles ahead of AW, partial strobe.
        bus.s_axi_wdata = 32'hDEAD_BEEF; bus.s_axi_wstrb = 4'b0011; bus.s_axi_wvalid = 1'b1;
        bq.push_back(1'b1);
        @(posedge clk); #1;
        bus.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("w_first_wready", 32'(bus.s_axi_wready), 32'd0);
        check("w_first_awready", 32'(bus.s_axi_awready), 32'd1);
        check("w_first_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.s_axi_awaddr = 32'h200; bus.s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        wait_b();
        push_r(4'd3, 32'h1122_BEEF, 1'b1);
        do_ar(4'd3, 32'h200, 4'd0, lat);
        wait_r();

        // AW and W together with B back-pressure.
        bus.s_axi_bready = 1'b0;
        bus.s_axi_awaddr = 32'h204; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h5566_7788; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        bq.push_back(1'b1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        for (int i = 0; i < 10 && !bus.s_axi_bvalid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_bvalid",  32'(bus.s_axi_bvalid),  32'd1);
            check("bhold_awready", 32'(bus.s_axi_awready), 32'd0);
            check("bhold_wready",  32'(bus.s_axi_wready),  32'd0);
        end
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check("b_after_bvalid",  32'(bus.s_axi_bvalid),  32'd0);
        check("b_after_awready", 32'(bus.s_axi_awready), 32'd1);
        check("b_after_wready",  32'(bus.s_axi_wready),  32'd1);
        check("b_after_queue",   32'(bq.size()),         32'd0);
        push_r(4'd6, 32'h5566_7788, 1'b1);
        do_ar(4'd6, 32'h204, 4'd0, lat);
        wait_r();

        // Read data load on the same edge as a write commit to the same word.
        ar_t  = (RDL == 0) ? 1 : 0;
        w_t   = ar_t + RDL - 1;
        t_max = (ar_t > w_t) ? ar_t : w_t;
        push_r(4'd4, 32'h0BAD_F00D, 1'b1);
        bq.push_back(1'b1);
        for (int t = 0; t <= t_max; t++) begin
            if (t == ar_t) begin
                bus.s_axi_arid = 4'd4; bus.s_axi_araddr = 32'h300; bus.s_axi_arlen = 4'd0;
                bus.s_axi_arvalid = 1'b1;
            end
            if (t == w_t) begin
                bus.s_axi_awaddr = 32'h300; bus.s_axi_awvalid = 1'b1;
                bus.s_axi_wdata = 32'hCAFE_0001; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
            end
            @(posedge clk); #1;
            bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        end
        wait_r();
        wait_b();
        push_r(4'd4, 32'hCAFE_0001, 1'b1);
        do_ar(4'd4, 32'h300, 4'd0, lat);
        wait_r();

        // Reset during beat 2 of a four-beat burst.
        push_r(4'd5, A0, 1'b0); push_r(4'd5, A1, 1'b0);
        push_r(4'd5, A2, 1'b0); push_r(4'd5, A3, 1'b1);
        do_ar(4'd5, 32'h100, 4'd3, lat);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.s_axi_rready = 1'b0;
        @(posedge clk); #1;
        rq.delete();
        check("midrst_rvalid",  32'(bus.s_axi_rvalid),  32'd0);
        check("midrst_arready", 32'(bus.s_axi_arready), 32'd0);
        reset = 1'b0;
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        check("relrst_arready", 32'(bus.s_axi_arready), 32'd1);
        @(negedge clk);
        check("relrst_no_beat", 32'(bus.s_axi_rvalid), 32'd0);
        @(posedge clk); #1;
        push_r(4'd7, A1, 1'b1);
        do_ar(4'd7, 32'h104, 4'd0, lat);
        wait_r();

        check("final_rq", 32'(rq.size()), 32'd0);
        check("final_bq", 32'(bq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
